regression_sequencer: RTL and testbench

// - Sequences the least-squares datapath: transpose -> {X^T*X, X^T*y} -> 2x2 inverse -> final multiply.
// - Issues one-cycle start pulses and collects done pulses; flags a singular matrix; reports total latency.
// - Sits between input_matrix (go) and the transpose/multiply/inverse units inside linear_regression.

---
 rtl/regression_pkg.sv | 16 +
 rtl/regression_sequencer_edge_detect.sv | 19 +
 rtl/regression_sequencer.sv | 166 ++++++++++++++++
 tb/tb_regression_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regression_pkg.sv
// Shared state encoding for the least-squares regression sequencer.
package regression_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    IDLE = 3'd0,
    TR   = 3'd1,
    MUL  = 3'd2,
    INV  = 3'd3,
    FIN  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

endpackage

// File: rtl/regression_sequencer_edge_detect.sv
// Registered rising-edge detector; the output is combinational off the
// live input so a start can be issued in the same cycle the edge appears.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  always_ff @(posedge clk) begin
    if (rst) sig_d <= 1'b0;
    else     sig_d <= sig;
  end

  assign rise = sig & ~sig_d;

endmodule

// File: rtl/regression_sequencer.sv
// Sequences transpose -> {X^T*X, X^T*y} -> 2x2 inverse -> final multiply.
// Define SEQ_TIMEOUT_EN to enable the per-stage watchdog (error_timeout).
module regression_sequencer
  import regression_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 ack,
  input  logic                 done_tr,
  input  logic                 done_xtx,
  input  logic                 done_xty,
  input  logic                 done_inv,
  input  logic                 invalid,
  input  logic                 done_fin,
  output logic                 start_tr,
  output logic                 start_mul,
  output logic                 start_inv,
  output logic                 start_fin,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 error_det,
  output logic                 error_timeout,
  output logic [STAGE_W-1:0]   stage,
  output logic [CNT_WIDTH-1:0] cycles
);

`ifdef SEQ_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(TIMEOUT - 1);

  state_t state, state_n;
  logic rise;
  logic got_xtx, got_xty, got_inv, inv_bad, inv_started;
  logic [CNT_WIDTH-1:0] cyc_cnt, wd_cnt;
  logic tr_c, mul_c, inv_c, fin_c;
  logic clr_flags, start_run, det_fail, to_timeout;
  logic timeout_hit, inv_seen, inv_is_bad;

  edge_detect u_go_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (go),
    .rise (rise)
  );

  assign busy        = (state == TR) || (state == MUL) || (state == INV) || (state == FIN);
  assign timeout_hit = WD_EN && busy && (wd_cnt == WD_LIMIT);
  // The inverse may finish while the X^T*y product is still outstanding in MUL.
  assign inv_seen    = got_inv | done_inv;
  assign inv_is_bad  = got_inv ? inv_bad : invalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      got_xtx       <= 1'b0;
      got_xty       <= 1'b0;
      got_inv       <= 1'b0;
      inv_bad       <= 1'b0;
      inv_started   <= 1'b0;
      cyc_cnt       <= '0;
      wd_cnt        <= '0;
      result_valid  <= 1'b0;
      error_det     <= 1'b0;
      error_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (clr_flags) begin
        got_xtx     <= 1'b0;
        got_xty     <= 1'b0;
        got_inv     <= 1'b0;
        inv_bad     <= 1'b0;
        inv_started <= 1'b0;
      end else begin
        if (state == MUL && done_xtx) got_xtx <= 1'b1;
        if (state == MUL && done_xty) got_xty <= 1'b1;
        if (inv_c) inv_started <= 1'b1;
        if (done_inv && ((state == MUL && inv_started) || state == INV)) begin
          got_inv <= 1'b1;
          inv_bad <= invalid;
        end
      end
      if (start_run)                  cyc_cnt <= '0;
      else if (busy && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
      if (state_n != state) wd_cnt <= '0;
      else if (busy)        wd_cnt <= wd_cnt + 1'b1;
      result_valid <= (state_n == DONE);
      // Error flags latch their cause on ERR entry and clear on any exit.
      if (state_n != ERR) begin
        error_det     <= 1'b0;
        error_timeout <= 1'b0;
      end else if (state != ERR) begin
        error_det     <= det_fail;
        error_timeout <= to_timeout;
      end
    end
  end

  always_comb begin
    state_n    = state;
    tr_c       = 1'b0;
    mul_c      = 1'b0;
    inv_c      = 1'b0;
    fin_c      = 1'b0;
    clr_flags  = 1'b0;
    start_run  = 1'b0;
    det_fail   = 1'b0;
    to_timeout = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n   = TR;
        tr_c      = 1'b1;
        start_run = 1'b1;
      end
      TR: if (done_tr) begin
        state_n   = MUL;
        mul_c     = 1'b1;
        clr_flags = 1'b1;
      end
      MUL: begin
        if ((got_xtx | done_xtx) && !inv_started) inv_c = 1'b1;
        if ((got_xtx | done_xtx) && (got_xty | done_xty)) state_n = INV;
      end
      INV: if (inv_seen) begin
        if (inv_is_bad) begin
          state_n  = ERR;
          det_fail = 1'b1;
        end else if (got_xty) begin
          state_n = FIN;
          fin_c   = 1'b1;
        end
      end
      FIN: if (done_fin) state_n = DONE;
      DONE, ERR: begin
        if (rise) begin
          state_n   = TR;
          tr_c      = 1'b1;
          start_run = 1'b1;
        end else if (ack) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Forward progress in the same cycle wins over the watchdog.
    if (timeout_hit && state_n == state) begin
      state_n    = ERR;
      inv_c      = 1'b0;
      to_timeout = 1'b1;
    end
  end

  assign start_tr  = tr_c  & ~rst;
  assign start_mul = mul_c & ~rst;
  assign start_inv = inv_c & ~rst;
  assign start_fin = fin_c & ~rst;
  assign stage     = state;
  assign cycles    = cyc_cnt;

endmodule

// File: tb/tb_regression_sequencer.sv
// Scoreboarded directed bench for regression_sequencer; set SEQ_TIMEOUT_EN
// to also exercise the stage watchdog.
module tb_regression_sequencer;
  import regression_pkg::*;

  localparam int W  = 4;
  localparam int TO = 16;

  localparam logic [7:0] GO    = 8'h80;
  localparam logic [7:0] ACK   = 8'h40;
  localparam logic [7:0] DTR   = 8'h20;
  localparam logic [7:0] DXTX  = 8'h10;
  localparam logic [7:0] DXTY  = 8'h08;
  localparam logic [7:0] DINV  = 8'h04;
  localparam logic [7:0] INVAL = 8'h02;
  localparam logic [7:0] DFIN  = 8'h01;

  localparam int EV_TR = 1, EV_MUL = 2, EV_INV = 3, EV_FIN = 4;
  localparam int EV_RES = 5, EV_DET = 6, EV_TO = 7;

  logic clk = 1'b0;
  logic rst, go, ack, done_tr, done_xtx, done_xty, done_inv, invalid, done_fin;
  logic start_tr, start_mul, start_inv, start_fin;
  logic busy, result_valid, error_det, error_timeout;
  logic [STAGE_W-1:0] stage;
  logic [W-1:0] cycles;

  typedef struct {
    int code;
    int value;
  } ev_t;

  ev_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int run_start = 0;
  logic prev_rv = 1'b0;
  logic prev_ed = 1'b0;
  logic prev_et = 1'b0;

  always #5 clk = ~clk;

  regression_sequencer #(.CNT_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .ack           (ack),
    .done_tr       (done_tr),
    .done_xtx      (done_xtx),
    .done_xty      (done_xty),
    .done_inv      (done_inv),
    .invalid       (invalid),
    .done_fin      (done_fin),
    .start_tr      (start_tr),
    .start_mul     (start_mul),
    .start_inv     (start_inv),
    .start_fin     (start_fin),
    .busy          (busy),
    .result_valid  (result_valid),
    .error_det     (error_det),
    .error_timeout (error_timeout),
    .stage         (stage),
    .cycles        (cycles)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic expect_ev(input int code, input int value);
    ev_t e;
    e.code  = code;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic observe_ev(input int code, input int value);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", code, 0);
    end else begin
      e = exp_q.pop_front();
      check("event_code", code, e.code);
      check("event_value", value, e.value);
    end
  endtask

  // Sampled at the falling edge so combinational start pulses are visible.
  task automatic checkOutput();
    if (start_tr)  observe_ev(EV_TR, 0);
    if (start_mul) observe_ev(EV_MUL, 0);
    if (start_inv) observe_ev(EV_INV, 0);
    if (start_fin) observe_ev(EV_FIN, 0);
    if (result_valid === 1'b1 && prev_rv !== 1'b1)  observe_ev(EV_RES, int'(cycles));
    if (error_det === 1'b1 && prev_ed !== 1'b1)     observe_ev(EV_DET, cyc - run_start);
    if (error_timeout === 1'b1 && prev_et !== 1'b1) observe_ev(EV_TO, cyc - run_start);
    prev_rv = result_valid;
    prev_ed = error_det;
    prev_et = error_timeout;
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    {go, ack, done_tr, done_xtx, done_xty, done_inv, invalid, done_fin} = v;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Standard run: done_tr@2, both products@4, done_inv@6, done_fin@t_fin.
  task automatic nominal_run(input int t_fin, input logic [7:0] base);
    int exp_cycles;
    exp_cycles = (t_fin > (1 << W) - 1) ? (1 << W) - 1 : t_fin;
    run_start = cyc;
    expect_ev(EV_TR, 0);
    applyStimulus(base | GO);
    applyStimulus(base);
    expect_ev(EV_MUL, 0);
    applyStimulus(base | DTR);
    applyStimulus(base);
    expect_ev(EV_INV, 0);
    applyStimulus(base | DXTX | DXTY);
    applyStimulus(base);
    expect_ev(EV_FIN, 0);
    applyStimulus(base | DINV);
    repeat (t_fin - 7) applyStimulus(base);
    expect_ev(EV_RES, exp_cycles);
    applyStimulus(base | DFIN);
    applyStimulus(base);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    {go, ack, done_tr, done_xtx, done_xty, done_inv, invalid, done_fin} = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    rst = 1'b0;
    check("reset_stage", stage, IDLE);
    check("reset_busy", busy, 0);
    check("reset_cycles", cycles, 0);
    check("reset_flags", {result_valid, error_det, error_timeout}, 0);
    check("reset_starts", {start_tr, start_mul, start_inv, start_fin}, 0);

    $display("[TB] nominal run");
    nominal_run(8, 8'h00);
    check("nominal_stage", stage, DONE);
    check("nominal_busy", busy, 0);
    check("nominal_valid", result_valid, 1);
    check("nominal_cycles_frozen", cycles, 8);
    applyStimulus(ACK);
    check("ack_clears_valid", result_valid, 0);
    check("ack_stage", stage, IDLE);

    $display("[TB] out-of-order products");
    run_start = cyc;
    expect_ev(EV_TR, 0);
    applyStimulus(GO);
    applyStimulus(8'h00);
    expect_ev(EV_MUL, 0);
    applyStimulus(DTR);
    applyStimulus(DXTY);
    applyStimulus(ACK);
    check("ack_while_busy_ignored", stage, MUL);
    applyStimulus(8'h00);
    expect_ev(EV_INV, 0);
    applyStimulus(DXTX);
    applyStimulus(8'h00);
    expect_ev(EV_FIN, 0);
    applyStimulus(DINV);
    applyStimulus(8'h00);
    expect_ev(EV_RES, 10);
    applyStimulus(DFIN);
    applyStimulus(8'h00);
    check("ooo_valid", result_valid, 1);
    applyStimulus(ACK);

    $display("[TB] singular matrix");
    run_start = cyc;
    expect_ev(EV_TR, 0);
    applyStimulus(GO);
    applyStimulus(8'h00);
    expect_ev(EV_MUL, 0);
    applyStimulus(DTR);
    applyStimulus(8'h00);
    expect_ev(EV_INV, 0);
    applyStimulus(DXTX | DXTY);
    applyStimulus(8'h00);
    expect_ev(EV_DET, 7);
    applyStimulus(DINV | INVAL);
    applyStimulus(8'h00);
    applyStimulus(DFIN);
    check("singular_stage", stage, ERR);
    check("singular_flags", {busy, result_valid, error_det, error_timeout}, 4'b0010);
    applyStimulus(ACK);
    check("singular_ack_stage", stage, IDLE);
    check("singular_ack_det", error_det, 0);

    $display("[TB] stray done and held go");
    applyStimulus(DFIN);
    check("stray_stage", stage, IDLE);
    check("stray_valid", result_valid, 0);
    nominal_run(8, GO);
    repeat (10) applyStimulus(GO);
    check("held_go_stage", stage, DONE);
    applyStimulus(8'h00);
    run_start = cyc;
    expect_ev(EV_TR, 0);
    applyStimulus(GO);
    check("restart_from_done_stage", stage, TR);
    check("restart_clears_valid", result_valid, 0);

    $display("[TB] reset mid-MUL");
    expect_ev(EV_MUL, 0);
    applyStimulus(DTR);
    rst = 1'b1;
    applyStimulus(DXTX);
    rst = 1'b0;
    check("midreset_stage", stage, IDLE);
    check("midreset_busy", busy, 0);
    check("midreset_cycles", cycles, 0);
    check("midreset_starts", {start_tr, start_mul, start_inv, start_fin}, 0);
    nominal_run(8, 8'h00);
    check("after_reset_valid", result_valid, 1);
    applyStimulus(ACK);

    $display("[TB] cycle counter saturation");
    nominal_run(20, 8'h00);
    check("saturated_cycles", cycles, (1 << W) - 1);
    applyStimulus(ACK);

`ifdef SEQ_TIMEOUT_EN
    $display("[TB] stage watchdog");
    run_start = cyc;
    expect_ev(EV_TR, 0);
    applyStimulus(GO);
    expect_ev(EV_TO, TO + 1);
    repeat (TO + 2) applyStimulus(8'h00);
    check("timeout_stage", stage, ERR);
    check("timeout_flags", {error_det, error_timeout}, 2'b01);
    applyStimulus(ACK);
    check("timeout_ack", error_timeout, 0);
`else
    check("timeout_tied_low", error_timeout, 0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
